adc_bridge_fifo: RTL and testbench



---
 rtl/adc_bridge_pkg.sv | 21 ++
 rtl/adc_res_fifo.sv | 60 ++++++
 rtl/adc_bridge_fifo.sv | 116 +++++++++++
 tb/tb_adc_bridge_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_bridge_pkg.sv
// Shared constants for the ADC serial bridge: result frame bit positions
// and helpers that size the config and result shift registers.
package adc_bridge_pkg;

  localparam int FRM_VALID    = 0;
  localparam int FRM_TAG      = 1;
  localparam int FRM_DATA_LSB = 2;
  // Overflow bit sits this many bits above the result width.
  localparam int FRM_OVF_OFS  = 2;

  // Result frame: valid, tag, RES_W result bits, overflow, one spare zero.
  function automatic int calcOutW(input int resW);
    return resW + 4;
  endfunction

  // Config frame: all config words plus the trailing commit bit.
  function automatic int calcSrW(input int nCfg, input int cfgW);
    return nCfg * cfgW + 1;
  endfunction

endpackage

// File: rtl/adc_res_fifo.sv
// Small synchronous FIFO for tagged conversion results. Pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
// A pop is served from the pre-push state; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module adc_res_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign level_o = wrPtr_q - rdPtr_q;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  // Decide which transfers happen this cycle and advance the pointers.
  always_comb begin
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/adc_bridge_fifo.sv
// Serial bridge between the 3-wire port and the SAR ADC core. Shifts in a
// committed config frame, buffers tagged conversion results in a FIFO and
// shifts the oldest result out after every load strobe.
module adc_bridge_fifo
  import adc_bridge_pkg::*;
#(
  parameter int CFG_W = 16,
  parameter int N_CFG = 2,
  parameter int RES_W = 16,
  parameter int DEPTH = 4,
  parameter logic [N_CFG*CFG_W-1:0] CFG_RESET = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dat_i,
  input  logic                     load,
  input  logic [RES_W-1:0]         adc_res,
  input  logic                     adc_conv_finished,
  input  logic                     adc_conv_finished_osr,
  output logic [N_CFG*CFG_W-1:0]   adc_cfg,
  output logic                     dat_o,
  output logic                     conv_finish,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     tie1,
  output logic                     tie0
);

  localparam int CFG_TOT = N_CFG * CFG_W;
  localparam int SR_W    = calcSrW(N_CFG, CFG_W);
  localparam int OUT_W   = calcOutW(RES_W);

  logic [SR_W-1:0]    cfgSr_q, cfgSr_d;
  logic [CFG_TOT-1:0] adcCfg_q, adcCfg_d;
  logic [OUT_W-1:0]   outSr_q, outSr_d;
  logic               ovfFlag_q, ovfFlag_d;
  logic [OUT_W-1:0]   frame;

  logic               fifoPush;
  logic [RES_W:0]     fifoWdata;
  logic [RES_W:0]     fifoRdata;
  logic               fifoFull;
  logic               fifoEmpty;

  // Either strobe pushes one entry; the OSR strobe wins the tag.
  assign fifoPush  = adc_conv_finished | adc_conv_finished_osr;
  assign fifoWdata = {adc_conv_finished_osr, adc_res};

  adc_res_fifo #(
    .WIDTH (RES_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .wdata_i (fifoWdata),
    .pop_i   (load),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  assign adc_cfg     = adcCfg_q;
  assign dat_o       = outSr_q[0];
  assign conv_finish = !fifoEmpty;
  assign tie1        = 1'b1;
  assign tie0        = 1'b0;

  // Config path: shift in while idle, commit only a frame with its commit bit set, always clear on load.
  always_comb begin
    cfgSr_d  = cfgSr_q;
    adcCfg_d = adcCfg_q;
    if (load) begin
      if (cfgSr_q[SR_W-1]) adcCfg_d = cfgSr_q[SR_W-2:0];
      cfgSr_d = '0;
    end else begin
      cfgSr_d = {dat_i, cfgSr_q[SR_W-1:1]};
    end
  end

  // Result path: build the frame from the FIFO head on load, otherwise shift it out LSB first.
  always_comb begin
    frame = '0;
    if (!fifoEmpty) begin
      frame[FRM_VALID]                = 1'b1;
      frame[FRM_TAG]                  = fifoRdata[RES_W];
      frame[FRM_DATA_LSB +: RES_W]    = fifoRdata[RES_W-1:0];
    end
    frame[RES_W + FRM_OVF_OFS] = ovfFlag_q;
    if (load) outSr_d = frame;
    else      outSr_d = {1'b0, outSr_q[OUT_W-1:1]};
  end

  // Sticky overflow: reported in the next frame, then cleared by that load.
  always_comb begin
    ovfFlag_d = ovfFlag_q;
    if (load)                      ovfFlag_d = 1'b0;
    else if (fifoPush && fifoFull) ovfFlag_d = 1'b1;
  end

  // State registers for both shift paths and the overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfgSr_q   <= '0;
      adcCfg_q  <= CFG_RESET;
      outSr_q   <= '0;
      ovfFlag_q <= 1'b0;
    end else begin
      cfgSr_q   <= cfgSr_d;
      adcCfg_q  <= adcCfg_d;
      outSr_q   <= outSr_d;
      ovfFlag_q <= ovfFlag_d;
    end
  end

endmodule

// File: tb/tb_adc_bridge_fifo.sv
// Self-checking bench for adc_bridge_fifo: a behavioural model predicts each
// result frame when its load is driven; frames are compared after shift-out.
module tb_adc_bridge_fifo;

  localparam int CFG_W = 16;
  localparam int N_CFG = 2;
  localparam int RES_W = 16;
  localparam int DEPTH = 4;
  localparam int SR_W  = N_CFG * CFG_W + 1;
  localparam int OUT_W = RES_W + 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   dat_i;
  logic                   load;
  logic [RES_W-1:0]       adc_res;
  logic                   adc_conv_finished;
  logic                   adc_conv_finished_osr;
  logic [N_CFG*CFG_W-1:0] adc_cfg;
  logic                   dat_o;
  logic                   conv_finish;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   tie1;
  logic                   tie0;

  adc_bridge_fifo #(
    .CFG_W     (CFG_W),
    .N_CFG     (N_CFG),
    .RES_W     (RES_W),
    .DEPTH     (DEPTH),
    .CFG_RESET ('0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dat_i                 (dat_i),
    .load                  (load),
    .adc_res               (adc_res),
    .adc_conv_finished     (adc_conv_finished),
    .adc_conv_finished_osr (adc_conv_finished_osr),
    .adc_cfg               (adc_cfg),
    .dat_o                 (dat_o),
    .conv_finish           (conv_finish),
    .fifo_level            (fifo_level),
    .tie1                  (tie1),
    .tie0                  (tie0)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [RES_W:0]   modelQ[$];
  logic [OUT_W-1:0] expQ[$];
  logic             modelOvf = 1'b0;

  // Count one comparison and report it if it differs.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model of one clock edge: a load takes the head first, then any push lands.
  task automatic modelStep(input logic ld, input logic pushS, input logic tag, input logic [RES_W-1:0] res);
    logic [OUT_W-1:0] f;
    logic [RES_W:0]   e;
    if (ld) begin
      f = '0;
      if (modelQ.size() > 0) begin
        e = modelQ.pop_front();
        f[0] = 1'b1;
        f[1] = e[RES_W];
        f[RES_W+1:2] = e[RES_W-1:0];
      end
      f[RES_W+2] = modelOvf;
      modelOvf = 1'b0;
      expQ.push_back(f);
    end
    if (pushS) begin
      if (modelQ.size() < DEPTH) modelQ.push_back({tag, res});
      else modelOvf = 1'b1;
    end
  endtask

  // Drive one cycle of inputs at the falling edge and advance the model.
  task automatic applyStimulus(input logic ld, input logic dat, input logic conv,
                               input logic convOsr, input logic [RES_W-1:0] res);
    @(negedge clk);
    load                  = ld;
    dat_i                 = dat;
    adc_conv_finished     = conv;
    adc_conv_finished_osr = convOsr;
    adc_res               = res;
    modelStep(ld, conv | convOsr, convOsr, res);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; load = 1'b0; dat_i = 1'b0;
    adc_conv_finished = 1'b0; adc_conv_finished_osr = 1'b0; adc_res = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    expQ.delete();
    modelOvf = 1'b0;
  endtask

  task automatic shiftCfg(input logic [SR_W-1:0] v);
    for (int i = 0; i < SR_W; i++) applyStimulus(1'b0, v[i], 1'b0, 1'b0, '0);
  endtask

  // Compare FIFO occupancy and the non-empty flag against the model.
  task automatic checkState(input string tag);
    checkOutput({tag, "_level"}, fifo_level, modelQ.size());
    checkOutput({tag, "_convFinish"}, conv_finish, modelQ.size() != 0);
  endtask

  // Issue a load (optionally with a push), shift the frame out and score it.
  task automatic readFrame(input string tag, input logic conv, input logic convOsr,
                           input logic [RES_W-1:0] res, output logic [OUT_W-1:0] got);
    logic [OUT_W-1:0] exp;
    applyStimulus(1'b1, 1'b0, conv, convOsr, res);
    for (int i = 0; i < OUT_W; i++) begin
      idle();
      got[i] = dat_o;
    end
    checkOutput({tag, "_sbDepth"}, expQ.size(), 1);
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput(tag, got, exp);
    end
  endtask

  logic [OUT_W-1:0] fr;

  initial begin
    rst = 1'b1; load = 1'b0; dat_i = 1'b0;
    adc_conv_finished = 1'b0; adc_conv_finished_osr = 1'b0; adc_res = '0;
    doReset();
    checkOutput("rstCfg", adc_cfg, 32'h0);
    checkOutput("rstDat", dat_o, 1'b0);
    checkOutput("rstTie1", tie1, 1'b1);
    checkOutput("rstTie0", tie0, 1'b0);
    checkState("rst");

    shiftCfg({1'b1, 16'h1234, 16'h5678});
    readFrame("cfgLoadFrame", 1'b0, 1'b0, '0, fr);
    checkOutput("cfgCommit", adc_cfg, 32'h1234_5678);
    readFrame("cfgReloadFrame", 1'b0, 1'b0, '0, fr);
    checkOutput("cfgReload", adc_cfg, 32'h1234_5678);

    shiftCfg({1'b0, 16'hffff, 16'hffff});
    readFrame("cfgNoCommitFrame", 1'b0, 1'b0, '0, fr);
    checkOutput("cfgNoCommit", adc_cfg, 32'h1234_5678);
    checkOutput("cfgSrCleared", dut.cfgSr_q, '0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'habcd);
    idle();
    checkState("onePush");
    readFrame("single", 1'b0, 1'b0, '0, fr);
    checkOutput("singleData", fr[17:2], 16'habcd);
    checkOutput("singleValidTag", fr[1:0], 2'b01);
    checkOutput("singleOvf", fr[18], 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'habcd);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'hdcba);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
    idle();
    checkState("threePush");
    readFrame("order0", 1'b0, 1'b0, '0, fr);
    readFrame("order1", 1'b0, 1'b0, '0, fr);
    checkOutput("order1Tag", fr[1], 1'b1);
    readFrame("order2", 1'b0, 1'b0, '0, fr);
    readFrame("emptyFrame", 1'b0, 1'b0, '0, fr);
    checkOutput("emptyValid", fr[0], 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h5a5a);
    idle();
    readFrame("bothStrobes", 1'b0, 1'b0, '0, fr);
    checkOutput("bothStrobesTag", fr[1], 1'b1);

    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
    idle();
    checkState("sixPush");
    readFrame("ovfSet", 1'b0, 1'b0, '0, fr);
    checkOutput("ovfSetBit", fr[18], 1'b1);
    readFrame("ovfClr", 1'b0, 1'b0, '0, fr);
    checkOutput("ovfClrBit", fr[18], 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0aa0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0bb0);
    idle();
    checkState("refill");
    readFrame("pushPopFull", 1'b1, 1'b0, 16'h0cc0, fr);
    checkState("pushPopFull");
    for (int i = 0; i < DEPTH; i++) readFrame("drain", 1'b0, 1'b0, '0, fr);
    checkOutput("drainLastData", fr[17:2], 16'h0cc0);
    checkOutput("drainOvf", fr[18], 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'hffff);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) idle();
    shiftCfg({1'b1, 32'h0});
    doReset();
    checkOutput("midRstDat", dat_o, 1'b0);
    checkOutput("midRstCfg", adc_cfg, 32'h0);
    checkState("midRst");
    readFrame("postRst", 1'b0, 1'b0, '0, fr);
    checkOutput("postRstCfg", adc_cfg, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
